// File: rtl/qspi_resp.sv
// Quad-SPI memory responder: decodes command + 24-bit address, then streams read nibbles
// out or absorbs write nibbles in. Write support is built only when QSPI_RESP_WRITE_EN is defined.
module qspi_resp #(
  parameter int DEPTH = 4096,
  parameter int DUMMY = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cs_n,
  input  logic [3:0] dq_in,
  output logic [3:0] dq_out,
  output logic [3:0] dq_oe,
  output logic       active,
  output logic       err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [7:0] CMD_READ  = 8'hEB;
  localparam logic [7:0] CMD_WRITE = 8'h38;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_RDATA, ST_WDATA, ST_IGNORE
  } state_t;

  state_t          state, state_nxt;
  logic [3:0]      cmd_hi;
  logic            is_write;
  logic [AW-1:0]   addr;
  logic [3:0]      cnt;
  logic            lo_phase;
  logic            oe_reg;
  logic [7:0]      cmd_byte;
  logic            cmd_read, cmd_write;
  logic            mem_we;
  logic [7:0]      mem_wdata;
  logic [7:0]      mem [DEPTH];

`ifdef QSPI_RESP_WRITE_EN
  logic [3:0]      wr_hi;
`endif

  // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    cmd_byte  = {cmd_hi, dq_in};
    cmd_read  = (cmd_byte == CMD_READ);
`ifdef QSPI_RESP_WRITE_EN
    cmd_write = (cmd_byte == CMD_WRITE);
    mem_we    = ~cs_n & (state == ST_WDATA) & lo_phase;
    mem_wdata = {wr_hi, dq_in};
`else
    // Read-only build: enable tied low, so the write port is pruned away.
    cmd_write = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = 8'h00;
`endif
    state_nxt = state;
    if (cs_n) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  state_nxt = ST_CMD;
        ST_CMD:   state_nxt = (cmd_read | cmd_write) ? ST_ADDR : ST_IGNORE;
        ST_ADDR:  if (cnt == 4'd5) state_nxt = is_write ? ST_WDATA : ST_DUMMY;
        ST_DUMMY: if (cnt == 4'(DUMMY - 1)) state_nxt = ST_RDATA;
        default:  state_nxt = state;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cmd_hi   <= 4'h0;
      is_write <= 1'b0;
      addr     <= '0;
      cnt      <= 4'd0;
      lo_phase <= 1'b0;
      oe_reg   <= 1'b0;
      dq_out   <= 4'h0;
      active   <= 1'b0;
      err      <= 1'b0;
`ifdef QSPI_RESP_WRITE_EN
      wr_hi    <= 4'h0;
`endif
    end else begin
      state  <= state_nxt;
      active <= (state_nxt != ST_IDLE);
      if (cs_n) begin
        cnt      <= 4'd0;
        lo_phase <= 1'b0;
        oe_reg   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: cmd_hi <= dq_in;
          ST_CMD: begin
            is_write <= cmd_write;
            cnt      <= 4'd0;
            if (!(cmd_read | cmd_write)) err <= 1'b1;
          end
          ST_ADDR: begin
            // Shifting all six nibbles leaves only the low AW address bits behind.
            addr     <= AW'({addr, dq_in});
            cnt      <= (cnt == 4'd5) ? 4'd0 : cnt + 4'd1;
            lo_phase <= 1'b0;
          end
          ST_DUMMY: begin
            cnt <= cnt + 4'd1;
            if (cnt == 4'(DUMMY - 1)) begin
              dq_out   <= mem[addr][7:4];
              oe_reg   <= 1'b1;
              lo_phase <= 1'b1;
            end
          end
          ST_RDATA: begin
            if (lo_phase) begin
              dq_out   <= mem[addr][3:0];
              addr     <= addr + 1'b1;
              lo_phase <= 1'b0;
            end else begin
              dq_out   <= mem[addr][7:4];
              lo_phase <= 1'b1;
            end
          end
`ifdef QSPI_RESP_WRITE_EN
          ST_WDATA: begin
            if (lo_phase) addr <= addr + 1'b1;
            else          wr_hi <= dq_in;
            lo_phase <= ~lo_phase;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  // NOTE: the storage array has no reset; contents survive reset_n.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr] <= mem_wdata;
  end

  assign dq_oe = {4{oe_reg & ~cs_n}};

endmodule

// File: tb/tb_qspi_resp.sv
// Self-checking bench for qspi_resp: reset, table-driven reads/bad commands, corner
// sequences (wrap, abort, reset mid-read) and randomized traffic against a byte-array model.
module tb_qspi_resp;

  localparam int DEPTH = 4096;
  localparam int DUMMY = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cs_n = 1'b1;
  logic [3:0] dq_in = 4'h0;
  logic [3:0] dq_out, dq_oe;
  logic       active, err;

  qspi_resp #(.DEPTH(DEPTH), .DUMMY(DUMMY)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .cs_n   (cs_n),
    .dq_in  (dq_in),
    .dq_out (dq_out),
    .dq_oe  (dq_oe),
    .active (active),
    .err    (err)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] model [DEPTH];
  logic       err_model = 1'b0;
  logic [7:0] rd [16];
  logic [7:0] wq [$];

  typedef struct {
    logic [7:0]  cmd;
    logic [23:0] addr;
    logic [15:0] data;
    logic        err;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One bus edge: drive inputs, let the edge happen, return at the following falling edge.
  task automatic step(input logic cs, input logic [3:0] nib);
    cs_n  = cs;
    dq_in = nib;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic deselect();
    cs_n = 1'b1;
    #1;
    check("oe_release_comb", dq_oe, 4'h0);
    step(1'b1, 4'h0);
    check("active_after_deselect", active, 1'b0);
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] addr);
    check("active_before_k0", active, 1'b0);
    step(1'b0, cmd[7:4]);
    check("active_after_k0", active, 1'b1);
    step(1'b0, cmd[3:0]);
    for (int i = 5; i >= 0; i--) step(1'b0, addr[i*4 +: 4]);
  endtask

  task automatic read_body(input int nbytes, input int stop_nib);
    check("oe_dummy", dq_oe, 4'h0);
    for (int d = 0; d < DUMMY; d++) begin
      step(1'b0, 4'($urandom));
      if (d < DUMMY - 1) check("oe_dummy", dq_oe, 4'h0);
    end
    for (int n = 0; n < 2 * nbytes && n < stop_nib; n++) begin
      check("oe_data", dq_oe, 4'hF);
      if (n % 2 == 0) rd[n/2][7:4] = dq_out;
      else            rd[n/2][3:0] = dq_out;
      if (n != 2 * nbytes - 1) step(1'b0, 4'($urandom));
    end
  endtask

  task automatic read_txn(input logic [23:0] addr, input int nbytes);
    send_hdr(8'hEB, addr);
    read_body(nbytes, 2 * nbytes);
    deselect();
  endtask

  task automatic write_txn(input logic [23:0] addr, input logic half, input logic [3:0] nib);
    send_hdr(8'h38, addr);
    foreach (wq[i]) begin
      step(1'b0, wq[i][7:4]);
      step(1'b0, wq[i][3:0]);
    end
    if (half) step(1'b0, nib);
    deselect();
  endtask

  task automatic bad_txn(input logic [7:0] cmd, input int extra);
    step(1'b0, cmd[7:4]);
    step(1'b0, cmd[3:0]);
    err_model = 1'b1;
    check("err_after_k1", err, 1'b1);
    check("active_ignore", active, 1'b1);
    for (int i = 0; i < extra; i++) begin
      step(1'b0, 4'($urandom));
      check("oe_ignore", dq_oe, 4'h0);
    end
    deselect();
  endtask

  task automatic preload(input int a, input logic [7:0] b0, input logic [7:0] b1);
    model[a % DEPTH]       = b0;
    model[(a + 1) % DEPTH] = b1;
`ifdef QSPI_RESP_WRITE_EN
    wq = {b0, b1};
    write_txn(24'(a), 1'b0, 4'h0);
`else
    dut.mem[a % DEPTH]       = b0;
    dut.mem[(a + 1) % DEPTH] = b1;
`endif
  endtask

  task automatic check_rd_model(input logic [23:0] addr, input int nbytes);
    for (int i = 0; i < nbytes; i++)
      check("rand_read_byte", rd[i], model[(int'(addr[11:0]) + i) % DEPTH]);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [23:0] a;
    logic [7:0]  c;
    int          r, n;
    logic        h;

    repeat (2) @(negedge clk);
    check("rst_dq_out", dq_out, 4'h0);
    check("rst_dq_oe", dq_oe, 4'h0);
    check("rst_active", active, 1'b0);
    check("rst_err", err, 1'b0);
    reset_n = 1'b1;
    step(1'b1, 4'h0);

    // Fill whole array with random bytes so every model entry is known.
    wq = {};
    for (int i = 0; i < DEPTH; i++) begin
      model[i] = 8'($urandom);
      wq.push_back(model[i]);
`ifndef QSPI_RESP_WRITE_EN
      dut.mem[i] = model[i];
`endif
    end
`ifdef QSPI_RESP_WRITE_EN
    write_txn(24'h000000, 1'b0, 4'h0);
`endif
    preload(32'h10, 8'hA5, 8'h3C);
    preload(DEPTH - 1, 8'h7E, 8'h81);
    preload(32'h20, 8'h55, 8'h66);

    vecs[0] = '{8'hEB, 24'h000010, 16'hA53C, 1'b0};
    vecs[1] = '{8'hEB, 24'h000FFF, 16'h7E81, 1'b0};
    vecs[2] = '{8'hEB, 24'hABC010, 16'hA53C, 1'b0};
    vecs[3] = '{8'hEB, 24'h000020, 16'h5566, 1'b0};
    vecs[4] = '{8'h12, 24'h000000, 16'h0000, 1'b1};
    vecs[5] = '{8'hEB, 24'h000010, 16'hA53C, 1'b1};
    vecs[6] = '{8'hEB, 24'hFFFFFF, 16'h7E81, 1'b1};
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].cmd == 8'hEB) begin
        read_txn(vecs[i].addr, 2);
        check("vec_byte0", rd[0], vecs[i].data[15:8]);
        check("vec_byte1", rd[1], vecs[i].data[7:0]);
      end else begin
        bad_txn(vecs[i].cmd, 3);
      end
      check("vec_err", err, vecs[i].err);
    end

    // Reset asserted in the middle of RDATA.
    send_hdr(8'hEB, 24'h000010);
    read_body(2, 2);
    check("oe_before_reset", dq_oe, 4'hF);
    reset_n = 1'b0;
    #1;
    check("reset_mid_oe", dq_oe, 4'h0);
    check("reset_mid_active", active, 1'b0);
    check("reset_mid_err", err, 1'b0);
    check("reset_mid_dq_out", dq_out, 4'h0);
    err_model = 1'b0;
    step(1'b1, 4'h0);
    reset_n = 1'b1;
    step(1'b1, 4'h0);
    read_txn(24'h000010, 2);
    check("after_reset_byte0", rd[0], 8'hA5);
    check("after_reset_byte1", rd[1], 8'h3C);

`ifdef QSPI_RESP_WRITE_EN
    // Abort after a single data nibble: no write may happen.
    wq = {};
    write_txn(24'h000020, 1'b1, 4'hF);
    check("abort_err", err, 1'b0);
    read_txn(24'h000020, 1);
    check("abort_keeps_old", rd[0], 8'h55);
`else
    wq = {8'hAA};
    write_txn(24'h000000, 1'b0, 4'h0);
    err_model = 1'b1;
    check("ro_write_err", err, 1'b1);
    read_txn(24'h000000, 1);
    check("ro_write_ignored", rd[0], 8'h81);
`endif

    for (int t = 0; t < 60; t++) begin
      r = $urandom_range(0, 9);
      a = 24'($urandom);
`ifdef QSPI_RESP_WRITE_EN
      if (r >= 5 && r <= 8) begin
        n = $urandom_range(0, 5);
        h = 1'($urandom);
        wq = {};
        for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
        write_txn(a, h, 4'($urandom));
        for (int i = 0; i < n; i++) model[(int'(a[11:0]) + i) % DEPTH] = wq[i];
      end else
`endif
      if (r == 9) begin
        do c = 8'($urandom);
`ifdef QSPI_RESP_WRITE_EN
        while (c == 8'hEB || c == 8'h38);
`else
        while (c == 8'hEB);
`endif
        bad_txn(c, $urandom_range(0, 3));
      end else begin
        n = $urandom_range(1, 8);
        read_txn(a, n);
        check_rd_model(a, n);
      end
      check("rand_err", err, err_model);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qspi_resp.md
# qspi_resp

Synthesizable quad-SPI memory responder: the target end of the QSPI bus that the core's QSPI cache-line engine drives. It holds a byte array, decodes a command byte and a 24-bit address, then streams read nibbles out or absorbs write nibbles in. It runs on the same `clk` that the core exports as the bus clock, and is used as the on-board memory for FPGA bring-up and as the bus target in system benches.

## Interface
- `DEPTH`, 4096 — bytes of storage, power of two; address bits above log2(DEPTH) ignored.
- `DUMMY`, 4 — dummy cycles between address and read data; legal range 1..15.
- `clk` input 1 — sole clock; bus sampled and driven on rising edge.
- `reset_n` input 1 — asynchronous, active-low reset.
- `cs_n` input 1 — chip select, active low.
- `dq_in` input 4 — bus nibble from master.
- `dq_out` output 4 — bus nibble to master; registered.
- `dq_oe` output 4 — output enable; all four bits equal.
- `active` output 1 — high while a transaction is in progress (state ≠ IDLE).
- `err` output 1 — sticky: unsupported command seen; cleared only by reset.

## Operation
- States: IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE.
- All nibbles travel most-significant first. Bytes travel high nibble then low nibble.
- Cycle k is the k-th rising edge with `cs_n` low, counting from 0.
- IDLE→CMD on the first edge with `cs_n` low. That edge samples command nibble 0.
- CMD: 2 nibbles (k=0,1) form the command byte.
- ADDR: 6 nibbles (k=2..7) form address A[23:0].
- Command 0xEB (quad read): ADDR→DUMMY→RDATA.
- Command 0x38 (quad write): ADDR→WDATA. This path is gated by the configuration macro.
- Any other command: at k=1, set `err`=1 and enter IGNORE.
- DUMMY: `DUMMY` cycles; `dq_oe`=0 throughout. `dq_in` is ignored.
- RDATA: `dq_out` presents mem[A] high nibble, then low nibble, then mem[A+1], and so on for as long as `cs_n` stays low.
- WDATA: nibble pairs are assembled. mem[A] is written on the edge sampling the low nibble, then A increments.
- Address arithmetic is modulo DEPTH: (DEPTH-1)+1 wraps to 0 for both read and write.
- `cs_n` high on any edge: next state IDLE and the nibble counter clears.
- A partially received write byte (one nibble) is discarded; no memory write occurs.
- `dq_oe` = oe_reg & ~cs_n, so the bus is released combinationally the moment `cs_n` rises.
- IGNORE: drives nothing and holds until `cs_n` goes high.
- A new transaction may start on the edge immediately after the one that saw `cs_n` high (minimum 1 cycle deselect).

## Timing
- Reset values: state IDLE, `dq_out`=0, `dq_oe`=0, `active`=0, `err`=0, address/counters 0.
- Reset does not clear memory contents.
- Reset asserted mid-transaction: `dq_oe` drops to 0 asynchronously and the state returns to IDLE.
- Read latency: the first data nibble is valid on `dq_out` with `dq_oe`=4'hF during cycle 8+DUMMY. It is registered at the edge ending cycle 7+DUMMY.
- Read throughput: one nibble per clock thereafter.
- Write: the memory update is visible to a read that starts on the next transaction.
- `active` is registered: it rises after edge k=0 and falls on the edge that samples `cs_n` high.

## Configuration
- `QSPI_RESP_WRITE_EN` defined: command 0x38 is supported as described above.
- `QSPI_RESP_WRITE_EN` undefined:
  - 0x38 is treated as an unsupported command: `err` is set and the state goes to IGNORE.
  - The memory write port and WDATA state are not built.
  - The array is read-only and must be loaded by `$readmemh` or by bench backdoor.

## Test plan
- Write then read back (macro on, DUMMY=4): write cmd 0x38, addr 0x000010, data A5 3C; deselect; read cmd 0xEB, addr 0x000010 → nibbles A,5,3,C on `dq_out` starting at cycle 12; `dq_oe`=F from cycle 12 and 0 in cycles 8–11.
- Wrap: preload mem[DEPTH-1]=0x7E and mem[0]=0x81; read from DEPTH-1 → nibbles 7,E,8,1.
- Bad command: cmd 0x12 → `err`=1 after cycle 1, `dq_oe` stays 0 to deselect; next 0xEB read still returns correct data and `err` stays 1.
- Abort: write to 0x20 (old value 0x55), raise `cs_n` after one data nibble 0xF → mem[0x20] still 0x55 on readback.
- Reset mid-read: assert `reset_n`=0 during RDATA → `dq_oe`=0 in the same cycle, `active`=0; after release, a new read returns the unchanged memory.
- Macro off: cmd 0x38 with data 0xAA to addr 0 → `err`=1 and a later read of addr 0 returns the preloaded value.
